// File: rtl/information_mapper_pkg.sv
// Shared helpers for the information mapper: bit counting and buffer sizing.
package information_mapper_pkg;

  // Widest word the helpers accept; callers zero-extend narrower words.
  localparam int MAX_P = 64;
  localparam int DEFAULT_P = 8;
  localparam int FILL_W = $clog2(2 * DEFAULT_P + 1);

  function automatic int popcount(input logic [MAX_P-1:0] w);
    int c;
    c = 0;
    for (int j = 0; j < MAX_P; j++) begin
      if (w[j]) c++;
    end
    return c;
  endfunction

  // Number of set bits strictly below position i (rank of bit i among the 1s).
  function automatic int rank(input logic [MAX_P-1:0] w, input int i);
    int c;
    c = 0;
    for (int j = 0; j < MAX_P; j++) begin
      if (j < i && w[j]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/information_mapper_expand.sv
// Combinational scatter of buffered information bits onto the 1-positions of a mapping word.
module information_mapper_expand
  import information_mapper_pkg::*;
#(
  parameter int P = 8
) (
  input  logic [P-1:0]             buf_lo,
  input  logic [P-1:0]             mapping,
  input  logic                     frozen_value,
  output logic [P-1:0]             mapped,
  output logic [$clog2(P+1)-1:0]   pc
);

  localparam int PCW   = $clog2(P + 1);
  localparam int IDX_W = $clog2(P);

  logic [IDX_W-1:0] k;

  always_comb begin
    k      = '0;
    mapped = '0;
    pc     = PCW'(popcount(MAX_P'(mapping)));
    for (int i = 0; i < P; i++) begin
      k         = IDX_W'(rank(MAX_P'(mapping), i));
      mapped[i] = mapping[i] ? buf_lo[k] : frozen_value;
    end
  end

endmodule

// File: rtl/information_mapper_stream.sv
// Streaming information mapper: residual bit buffer between data FIFO and mapped output words.
module information_mapper_stream
  import information_mapper_pkg::*;
#(
  parameter int MAPPER_PARALLELISM = 8,
  parameter int WORD_COUNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          frozen_value,
  input  logic [MAPPER_PARALLELISM-1:0] data_in_fifo_rd_data,
  input  logic                          data_in_fifo_empty,
  output logic                          data_in_fifo_rd_req,
  input  logic [MAPPER_PARALLELISM-1:0] mapping_fifo_rd_data,
  input  logic                          mapping_fifo_empty,
  output logic                          mapping_fifo_rd_req,
  output logic [MAPPER_PARALLELISM-1:0] data_out_fifo_wr_data,
  input  logic                          data_out_fifo_full,
  output logic                          data_out_fifo_wr_req,
  output logic [WORD_COUNT_WIDTH-1:0]   word_count
);

  localparam int P   = MAPPER_PARALLELISM;
  localparam int FW  = $clog2(2 * P + 1);
  localparam int PCW = $clog2(P + 1);

  logic [2*P-1:0]              bitbuf_q, bitbuf_d;
  logic [FW-1:0]               fill_q, fill_d;
  logic [WORD_COUNT_WIDTH-1:0] word_count_q, word_count_d;

  logic [P-1:0]   mapped;
  logic [PCW-1:0] pc;
  logic [FW-1:0]  pc_ext, fill_after, consumed;
  logic           fire, pop;

  information_mapper_expand #(.P(P)) u_expand (
    .buf_lo       (bitbuf_q[P-1:0]),
    .mapping      (mapping_fifo_rd_data),
    .frozen_value (frozen_value),
    .mapped       (mapped),
    .pc           (pc)
  );

  // Requests include the reset level so they drop the instant reset asserts.
  always_comb begin
    pc_ext     = FW'(pc);
    fire       = reset & enable & ~mapping_fifo_empty & ~data_out_fifo_full & (fill_q >= pc_ext);
    consumed   = fire ? pc_ext : '0;
    fill_after = fill_q - consumed;
    pop        = reset & enable & ~data_in_fifo_empty & (fill_after <= FW'(P));

    bitbuf_d = bitbuf_q >> consumed;
    if (pop) bitbuf_d = bitbuf_d | ((2*P)'(data_in_fifo_rd_data) << fill_after);
    fill_d = fill_after + (pop ? FW'(P) : FW'(0));

    word_count_d = word_count_q;
    if (fire) word_count_d = word_count_q + WORD_COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitbuf_q     <= '0;
      fill_q       <= '0;
      word_count_q <= '0;
    end else begin
      bitbuf_q     <= bitbuf_d;
      fill_q       <= fill_d;
      word_count_q <= word_count_d;
    end
  end

  assign data_in_fifo_rd_req   = pop;
  assign mapping_fifo_rd_req   = fire;
  assign data_out_fifo_wr_req  = fire;
  assign data_out_fifo_wr_data = reset ? mapped : '0;
  assign word_count            = word_count_q;

endmodule

// File: tb/tb_information_mapper_stream.sv
// Directed bench for information_mapper_stream with show-ahead FIFO models and hand-computed vectors.
module tb_information_mapper_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        frozen_value;
  logic [7:0]  din_data;
  logic        din_empty;
  logic        din_rd;
  logic [7:0]  map_data;
  logic        map_empty;
  logic        map_rd;
  logic [7:0]  dout_data;
  logic        dout_full;
  logic        dout_wr;
  logic [15:0] word_count;

  information_mapper_stream #(.MAPPER_PARALLELISM(8), .WORD_COUNT_WIDTH(16)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable                (enable),
    .frozen_value          (frozen_value),
    .data_in_fifo_rd_data  (din_data),
    .data_in_fifo_empty    (din_empty),
    .data_in_fifo_rd_req   (din_rd),
    .mapping_fifo_rd_data  (map_data),
    .mapping_fifo_empty    (map_empty),
    .mapping_fifo_rd_req   (map_rd),
    .data_out_fifo_wr_data (dout_data),
    .data_out_fifo_full    (dout_full),
    .data_out_fifo_wr_req  (dout_wr),
    .word_count            (word_count)
  );

  always #5 clk = ~clk;

  logic [7:0] dq[$];
  logic [7:0] mq[$];
  int outs[$];
  int wr_cyc[$];
  int pop_cyc[$];
  int fills[$];
  int tcount, stall_viol, fill_viol, any_din_rd;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic drive();
    din_empty = (dq.size() == 0);
    din_data  = (dq.size() != 0) ? dq[0] : 8'h00;
    map_empty = (mq.size() == 0);
    map_data  = (mq.size() != 0) ? mq[0] : 8'h00;
  endtask

  task automatic tick();
    logic do_din, do_map;
    drive();
    @(negedge clk);
    if (din_rd) begin
      pop_cyc.push_back(tcount);
      any_din_rd = 1;
    end
    if (dout_wr) begin
      wr_cyc.push_back(tcount);
      outs.push_back(int'(dout_data));
    end
    if (dout_full && (dout_wr || map_rd)) stall_viol++;
    fills.push_back(int'(dut.fill_q));
    if (int'(dut.fill_q) > 16) fill_viol++;
    do_din = din_rd;
    do_map = map_rd;
    @(posedge clk);
    #1;
    if (do_din && dq.size() != 0) void'(dq.pop_front());
    if (do_map && mq.size() != 0) void'(mq.pop_front());
    tcount++;
    drive();
  endtask

  task automatic clear_logs();
    outs.delete(); wr_cyc.delete(); pop_cyc.delete(); fills.delete();
    tcount = 0; stall_viol = 0; fill_viol = 0; any_din_rd = 0;
  endtask

  task automatic restart();
    reset = 1'b0;
    dq.delete(); mq.delete();
    dout_full = 1'b0; frozen_value = 1'b0; enable = 1'b1;
    drive();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    clear_logs();
    drive();
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; frozen_value = 1'b1; dout_full = 1'b0;
    // Reset held: inputs would otherwise trigger every request.
    mq.push_back(8'h00); dq.push_back(8'hA5);
    drive();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wr_req", int'(dout_wr), 0);
    chk("rst_map_rd", int'(map_rd), 0);
    chk("rst_din_rd", int'(din_rd), 0);
    chk("rst_wr_data", int'(dout_data), 0);
    chk("rst_fill", int'(dut.fill_q), 0);
    chk("rst_wcount", int'(word_count), 0);

    // All-ones mapping: one-cycle pop-to-write latency, then back-to-back.
    restart();
    mq = '{8'hFF, 8'hFF}; dq = '{8'hA5, 8'h3C};
    repeat (6) tick();
    chk("t1_nout", outs.size(), 2);
    chk("t1_out0", qget(outs, 0), 'hA5);
    chk("t1_out1", qget(outs, 1), 'h3C);
    chk("t1_lat", qget(wr_cyc, 0), qget(pop_cyc, 0) + 1);
    chk("t1_b2b", qget(wr_cyc, 1), qget(wr_cyc, 0) + 1);
    chk("t1_wcount", int'(word_count), 2);

    // All-zero mapping with frozen 1: no data needed, immediate writes.
    restart();
    frozen_value = 1'b1;
    mq = '{8'h00, 8'h00, 8'h00};
    repeat (5) tick();
    chk("t2_nout", outs.size(), 3);
    chk("t2_out0", qget(outs, 0), 'hFF);
    chk("t2_out2", qget(outs, 2), 'hFF);
    chk("t2_first", qget(wr_cyc, 0), 0);
    chk("t2_no_din", any_din_rd, 0);
    chk("t2_wcount", int'(word_count), 3);

    // Half mapping splits one data word across two outputs.
    restart();
    mq = '{8'h0F, 8'h0F}; dq = '{8'hB7};
    repeat (6) tick();
    chk("t3_nout", outs.size(), 2);
    chk("t3_out0", qget(outs, 0), 'h07);
    chk("t3_out1", qget(outs, 1), 'h0B);
    chk("t3_pops", pop_cyc.size(), 1);

    // Sparse mapping drains the buffer two bits at a time.
    restart();
    mq = '{8'h81, 8'h81, 8'h81, 8'h81}; dq = '{8'h01};
    repeat (7) tick();
    chk("t4_nout", outs.size(), 4);
    chk("t4_out0", qget(outs, 0), 'h01);
    chk("t4_out1", qget(outs, 1), 'h00);
    chk("t4_out3", qget(outs, 3), 'h00);
    chk("t4_pops", pop_cyc.size(), 1);
    chk("t4_fill1", qget(fills, 1), 8);
    chk("t4_fill2", qget(fills, 2), 6);
    chk("t4_fill3", qget(fills, 3), 4);
    chk("t4_fill4", qget(fills, 4), 2);
    chk("t4_fill5", qget(fills, 5), 0);

    // Output back-pressure for five cycles mid-stream.
    restart();
    mq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    dq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int c = 0; c < 16; c++) begin
      dout_full = (c >= 2 && c <= 6);
      tick();
    end
    dout_full = 1'b0;
    chk("t5_stall", stall_viol, 0);
    chk("t5_fillmax", fill_viol, 0);
    chk("t5_nout", outs.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t5_out%0d", i), qget(outs, i), 'h11 * (i + 1));
    chk("t5_wcount", int'(word_count), 6);

    // Asynchronous reset between edges discards the buffered bits.
    restart();
    mq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF}; dq = '{8'hAA, 8'hBB, 8'hCC};
    repeat (2) tick();
    chk("t6_pre_out", qget(outs, 0), 'hAA);
    #2 reset = 1'b0;
    #1;
    chk("t6_ar_wr", int'(dout_wr), 0);
    chk("t6_ar_map", int'(map_rd), 0);
    chk("t6_ar_din", int'(din_rd), 0);
    chk("t6_ar_fill", int'(dut.fill_q), 0);
    chk("t6_ar_wcount", int'(word_count), 0);
    chk("t6_ar_data", int'(dout_data), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    clear_logs();
    repeat (3) tick();
    chk("t6_first_wr", qget(wr_cyc, 0), 1);
    chk("t6_first_pop", qget(pop_cyc, 0), 0);
    chk("t6_out0", qget(outs, 0), 'hCC);
    chk("t6_wcount", int'(word_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
